// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_control
// Brief    : Registered ALU control decoder. Maps the main-decoder operation
//            class (alu_op) and the R-type function field (funct) to a 4-bit
//            ALU operation select, and flags unsupported alu_op/funct pairs.
//            Outputs come straight from flops and update only on an enabled
//            rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control #(
  parameter logic [3:0] RESET_CNT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_cnt,
  output logic       illegal
);

  // ALU operation codes (the top code bit is never set by the decoder)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // Operation classes presented by the main decoder
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_SLTI  = 3'b010;
  localparam logic [2:0] OP_ADDI  = 3'b011;
  localparam logic [2:0] OP_ANDI  = 3'b100;
  localparam logic [2:0] OP_ORI   = 3'b101;

  logic [3:0] next_cnt;
  logic       next_illegal;

  // Pure combinational decode of the current inputs; unsupported pairs fall
  // back to ADD so the datapath always sees a harmless operation.
  always_comb begin
    next_cnt     = ALU_ADD;
    next_illegal = 1'b0;
    case (alu_op)
      OP_RTYPE: begin
        if (funct[5:3] == 3'b000) begin
          // R-type functions 0..7 map one-to-one onto codes 0..7
          next_cnt = {1'b0, funct[2:0]};
        end else begin
          next_cnt     = ALU_ADD;
          next_illegal = 1'b1;
        end
      end
      OP_BEQ:  next_cnt = ALU_SUB;
      OP_SLTI: next_cnt = ALU_SLT;
      OP_ADDI: next_cnt = ALU_ADD;
      OP_ANDI: next_cnt = ALU_AND;
      OP_ORI:  next_cnt = ALU_OR;
      default: begin
        next_cnt     = ALU_ADD;
        next_illegal = 1'b1;
      end
    endcase
  end

  // Output registers: async active-low reset wins over everything, en gates
  // the capture, otherwise the previous decode is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt <= RESET_CNT;
      illegal <= 1'b0;
    end else if (en) begin
      alu_cnt <= next_cnt;
      illegal <= next_illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control
// Brief    : Self-checking bench for alu_control. A behavioural model holds
//            the expected registered outputs; directed scenarios plus a
//            randomized run are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [3:0] alu_cnt;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  // Model state: what the outputs should currently show
  logic [3:0] exp_cnt;
  logic       exp_ill;

  alu_control #(.RESET_CNT(4'b0000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_cnt (alu_cnt),
    .illegal (illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: ALU select per operation class, from a lookup table
  function automatic logic [4:0] model_decode(input logic [2:0] op, input logic [5:0] f);
    int class_code [8] = '{0, 1, 4, 0, 2, 3, 0, 0};
    int fv;
    fv = int'(f);
    if (op == 3'd0) begin
      if (fv < 8) return {1'b0, 4'(fv)};
      return {1'b1, 4'd0};
    end
    if (op >= 3'd6) return {1'b1, 4'd0};
    return {1'b0, 4'(class_code[op])};
  endfunction

  // One clock: drive at negedge, let the rising edge capture, sample 1 ns later
  task automatic step(input logic e, input logic [2:0] op, input logic [5:0] f);
    logic [4:0] d;
    @(negedge clk);
    en = e; alu_op = op; funct = f;
    @(posedge clk);
    if (e && rst_n) begin
      d = model_decode(op, f);
      exp_ill = d[4];
      exp_cnt = d[3:0];
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; alu_op = 3'd0; funct = 6'd5;
    exp_cnt = 4'd0; exp_ill = 1'b0;
    #2;
    checks++;
    if (alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_before_clk: got cnt=%b ill=%b, want cnt=0000 ill=0", alu_cnt, illegal);
    end
    // Reset must hold through a clock edge even with en=1
    @(posedge clk); #1;
    checks++;
    if (alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_through_edge: got cnt=%b ill=%b, want cnt=0000 ill=0", alu_cnt, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First enabled edge after release captures
    step(1'b1, 3'd0, 6'd6);
    checks++;
    if (alu_cnt !== 4'b0110 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL first_capture: got cnt=%b ill=%b, want cnt=0110 ill=0", alu_cnt, illegal);
    end
  endtask

  task automatic test_rtype_sweep();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd0, 6'(i));
      checks++;
      if (alu_cnt !== 4'(i) || illegal !== 1'b0) begin
        errors++;
        $display("FAIL rtype_sweep funct=%0d: got cnt=%b ill=%b, want cnt=%b ill=0", i, alu_cnt, illegal, 4'(i));
      end
    end
  endtask

  task automatic test_class_map();
    logic [3:0] want [5] = '{4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b0011};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i + 1), 6'b000111);
      checks++;
      if (alu_cnt !== want[i] || illegal !== 1'b0) begin
        errors++;
        $display("FAIL class_map op=%0d: got cnt=%b ill=%b, want cnt=%b ill=0", i + 1, alu_cnt, illegal, want[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [3] = '{3'd0, 3'd6, 3'd7};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ops[i], 6'b001000);
      checks++;
      if (alu_cnt !== 4'd0 || illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal op=%0d: got cnt=%b ill=%b, want cnt=0000 ill=1", ops[i], alu_cnt, illegal);
      end
    end
    step(1'b1, 3'd1, 6'b001000);
    checks++;
    if (alu_cnt !== 4'b0001 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got cnt=%b ill=%b, want cnt=0001 ill=0", alu_cnt, illegal);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 3'd2, 6'd0);
    checks++;
    if (alu_cnt !== 4'b0100) begin
      errors++;
      $display("FAIL hold_load: got cnt=%b, want 0100", alu_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd1, 6'd0);
      checks++;
      if (alu_cnt !== 4'b0100 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got cnt=%b ill=%b, want cnt=0100 ill=0", i, alu_cnt, illegal);
      end
    end
    step(1'b1, 3'd1, 6'd0);
    checks++;
    if (alu_cnt !== 4'b0001) begin
      errors++;
      $display("FAIL hold_release: got cnt=%b, want 0001", alu_cnt);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 3'd0, 6'd7);
    checks++;
    if (alu_cnt !== 4'b0111) begin
      errors++;
      $display("FAIL async_pre: got cnt=%b, want 0111", alu_cnt);
    end
    // Drop reset mid-cycle, away from any edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 4'd0; exp_ill = 1'b0;
    checks++;
    if (alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_assert: got cnt=%b ill=%b, want cnt=0000 ill=0", alu_cnt, illegal);
    end
    // Illegal flag is also cleared asynchronously
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 3'd7, 6'd0);
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 4'd0; exp_ill = 1'b0;
    checks++;
    if (alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_clear_illegal: got cnt=%b ill=%b, want cnt=0000 ill=0", alu_cnt, illegal);
    end
    // Pending enabled decode during reset must not land
    en = 1'b1; alu_op = 3'd5;
    @(posedge clk); #1;
    checks++;
    if (alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_override: got cnt=%b ill=%b, want cnt=0000 ill=0", alu_cnt, illegal);
    end
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 3'd5, 6'd0);
    checks++;
    if (alu_cnt !== 4'b0011 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_recover: got cnt=%b ill=%b, want cnt=0011 ill=0", alu_cnt, illegal);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic       e;
      logic [2:0] op;
      logic [5:0] f;
      e  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      // Bias funct towards the legal R-type range
      f  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      step(e, op, f);
      checks++;
      if (alu_cnt !== exp_cnt || illegal !== exp_ill) begin
        errors++;
        $display("FAIL random%0d en=%b op=%b f=%b: got cnt=%b ill=%b, want cnt=%b ill=%b",
                 i, e, op, f, alu_cnt, illegal, exp_cnt, exp_ill);
      end
      // Wiggle inputs between edges; outputs must not follow
      alu_op = 3'($urandom_range(0, 7));
      funct  = 6'($urandom_range(0, 63));
      en     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (alu_cnt !== exp_cnt || illegal !== exp_ill) begin
        errors++;
        $display("FAIL midcycle%0d: got cnt=%b ill=%b, want cnt=%b ill=%b",
                 i, alu_cnt, illegal, exp_cnt, exp_ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sweep();
    test_class_map();
    test_illegal();
    test_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
